mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 32, giving the maximum cycles waited for mul_finish when the watchdog is compiled in.
REQ-002 The block SHALL have a clk input, 1 bit: the single rising-edge clock.
REQ-003 The block SHALL have a reset_n input, 1 bit: synchronous active-low reset, sampled on the clk rising edge.
REQ-004 The block SHALL have a req input, 2 bits: request per requester; held high with operands stable until that requester's done.
REQ-005 The block SHALL have inputs a0 and b0, 4 bits each: requester 0 operands.
REQ-006 The block SHALL have inputs a1 and b1, 4 bits each: requester 1 operands.
REQ-007 The block SHALL have a gnt output, 2 bits: one-hot grant; at most one bit high.
REQ-008 The block SHALL have a done output, 2 bits: one-cycle completion pulse per requester.
REQ-009 The block SHALL have a product output, 8 bits: result; valid only while a done bit is high.
REQ-010 The block SHALL have an err output, 1 bit: one-cycle timeout flag, coincident with done.
REQ-011 The block SHALL have a mul_start output, 1 bit: start level to the shared 4x4 shift/add multiplier.
REQ-012 The block SHALL have outputs mul_a and mul_b, 4 bits each: multiplier operands, from latched registers.
REQ-013 The block SHALL have a mul_o input, 8 bits: multiplier product.
REQ-014 The block SHALL have a mul_finish input, 1 bit: multiplier completion; mul_o is valid in the same cycle.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE, advancing one state per clk edge except in WAIT.
REQ-016 In IDLE with req != 0, the FSM SHALL select the winner, go to ISSUE, and latch the winner's a/b into mul_a/mul_b.
REQ-017 When both req bits are high in the same cycle, the grant SHALL go to the requester not served last (round-robin); a single request SHALL be granted directly.
REQ-018 In ISSUE, the block SHALL assert gnt[winner] and mul_start=1, then go to WAIT.
REQ-019 In WAIT, mul_start SHALL stay 1; on mul_finish=1 the block SHALL capture mul_o and go to DONE.
REQ-020 In DONE, the block SHALL assert done[winner]=1, drive product with the captured value, set mul_start=0, update the last-served pointer and go to IDLE.
REQ-021 gnt[winner] SHALL be high from ISSUE through DONE inclusive, and low in IDLE.
REQ-022 Latency SHALL be exactly 3 cycles plus the multiplier's cycles in WAIT, measured from the req sample in IDLE to the done pulse.
REQ-023 mul_a/mul_b SHALL be held from the latched registers, so operand or req changes after ISSUE do not affect the running operation.
REQ-024 If req drops mid-operation, the operation SHALL still complete and done SHALL still pulse.
REQ-025 mul_finish outside WAIT SHALL be ignored.
REQ-026 The product SHALL be the full 8-bit value with no truncation; product SHALL be 0 when no done bit is high.
REQ-027 A requester whose req is still high in the IDLE cycle after its done SHALL be treated as a new request, subject to round-robin.

Reset
REQ-028 When reset_n=0 at a clk edge, the block SHALL enter IDLE regardless of state, including mid-WAIT.
REQ-029 Reset SHALL set gnt=0, done=0, err=0, product=0, mul_start=0, mul_a=0, mul_b=0 and the timeout counter to 0.
REQ-030 Reset SHALL set the last-served pointer to requester 1, so requester 0 wins the first tie.
REQ-031 The multiplier SHALL be reset externally by the same reset_n; an aborted operation SHALL produce no done.

Configuration
REQ-032 When macro MULT_ARBITER_TIMEOUT_EN is defined, a counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-033 With the macro defined, if TIMEOUT_CYCLES is reached without mul_finish, the block SHALL go to DONE with product=0 and err=1 for that cycle.
REQ-034 When MULT_ARBITER_TIMEOUT_EN is undefined, WAIT SHALL be unbounded, err SHALL be tied 0, and no counter SHALL exist.

Structure
REQ-035 Package mult_arbiter_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT/DONE), the OP_W=4 and PROD_W=8 constants, and the requester-count constant NREQ=2.
REQ-036 The two-requester round-robin selection with its last-served pointer SHALL be a sub-module named rr_arbiter2; the FSM and datapath SHALL stay in mult_arbiter.

Verification
REQ-037 Single request: req=01, a0=14, b0=11, with a model multiplier finishing after 9 cycles -> gnt=01 from ISSUE to DONE, done=01 for one cycle, product=154, latency 12 cycles.
REQ-038 Tie after reset: req=11, a0=3, b0=5, a1=15, b1=15 -> requester 0 first with product=15, then requester 1 with product=225; gnt never 11.
REQ-039 Operand change: a0 changed from 14 to 2 during WAIT -> mul_a stays 14 and product=154.
REQ-040 Reset mid-WAIT: reset_n=0 for one cycle -> all outputs 0 next cycle, no done; a following req=10, a1=9, b1=9 -> product=81.
REQ-041 Timeout (macro defined, TIMEOUT_CYCLES=32): mul_finish held 0 -> 32 WAIT cycles, then done=01, err=1, product=0; without the macro the block stays in WAIT with err=0.

Source files
------------

// File: rtl/mult_arbiter_pkg.sv
// mult_arbiter_pkg: shared types and constants for the two-requester
// multiplier arbiter.
//   state_t : arbiter FSM state (IDLE, ISSUE, WAIT, DONE)
//   OP_W    : operand width of the shared multiplier
//   PROD_W  : product width (full, untruncated)
//   NREQ    : number of requesters
//   onehot  : requester index -> one-hot grant/done vector
package mult_arbiter_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int NREQ   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: requester and multiplier-side signals of mult_arbiter.
//   req        : per-requester request, held with stable operands until done
//   a0/b0      : requester 0 operands
//   a1/b1      : requester 1 operands
//   gnt        : one-hot grant, high from ISSUE through DONE
//   done       : one-cycle completion pulse per requester
//   product    : result, nonzero only while a done bit is high
//   err        : one-cycle timeout flag, coincident with done
//   mul_start  : start level to the shared multiplier
//   mul_a/b    : latched multiplier operands
//   mul_o      : multiplier product
//   mul_finish : multiplier completion, mul_o valid in the same cycle
// Handshake: a requester raises req with operands stable and keeps them until
// its done pulse; the multiplier sees a level mul_start and answers with a
// single mul_finish cycle carrying mul_o.
// modport slave is the arbiter's view, master is the environment's view.
interface mult_arbiter_if;
  import mult_arbiter_pkg::*;

  logic [NREQ-1:0]   req;
  logic [OP_W-1:0]   a0;
  logic [OP_W-1:0]   b0;
  logic [OP_W-1:0]   a1;
  logic [OP_W-1:0]   b1;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [PROD_W-1:0] product;
  logic              err;
  logic              mul_start;
  logic [OP_W-1:0]   mul_a;
  logic [OP_W-1:0]   mul_b;
  logic [PROD_W-1:0] mul_o;
  logic              mul_finish;

  modport slave (
    input  req, a0, b0, a1, b1, mul_o, mul_finish,
    output gnt, done, product, err, mul_start, mul_a, mul_b
  );

  modport master (
    output req, a0, b0, a1, b1, mul_o, mul_finish,
    input  gnt, done, product, err, mul_start, mul_a, mul_b
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin selector with last-served pointer.
//   clk, reset_n : clock, synchronous active-low reset
//   req          : request vector
//   update       : load the last-served pointer with served
//   served       : index of the requester just completed
//   winner       : selected requester index (meaningful when req != 0)
// The pointer resets to requester 1 so requester 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic       winner
);

  logic last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last <= 1'b1;
    end else if (update) begin
      last <= served;
    end
  end

  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one 4x4 shift/add multiplier between two requesters.
//   clk       : rising-edge clock
//   reset_n   : synchronous active-low reset
//   bus       : mult_arbiter_if.slave (requesters + multiplier)
//   dbg_state : current FSM state
// Parameter TIMEOUT_CYCLES: WAIT cycles allowed before giving up on
// mul_finish. Only used when MULT_ARBITER_TIMEOUT_EN is defined; without it
// WAIT is unbounded and err is tied low.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  mult_arbiter_if.slave     bus,
  output state_t            dbg_state
);

  state_t            state;
  logic              winner_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic [PROD_W-1:0] product_q;
  logic              mul_start_q;
  logic [OP_W-1:0]   mul_a_q;
  logic [OP_W-1:0]   mul_b_q;
  logic              rr_winner;
  logic              rr_update;

`ifdef MULT_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             err_q;
`endif

  // The pointer moves while DONE is shown, so the next IDLE cycle already
  // sees the requester just served as "last".
  assign rr_update = (state == DONE);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.req),
    .update  (rr_update),
    .served  (winner_q),
    .winner  (rr_winner)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      winner_q    <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      product_q   <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
`ifdef MULT_ARBITER_TIMEOUT_EN
      to_cnt      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            // Operands are captured here so later changes cannot disturb
            // the running multiply.
            winner_q    <= rr_winner;
            gnt_q       <= onehot(rr_winner);
            mul_start_q <= 1'b1;
            mul_a_q     <= rr_winner ? bus.a1 : bus.a0;
            mul_b_q     <= rr_winner ? bus.b1 : bus.b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef MULT_ARBITER_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state  <= WAIT;
        end
        WAIT: begin
          if (bus.mul_finish) begin
            product_q   <= bus.mul_o;
            done_q      <= onehot(winner_q);
            mul_start_q <= 1'b0;
            state       <= DONE;
          end
`ifdef MULT_ARBITER_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            product_q   <= '0;
            done_q      <= onehot(winner_q);
            err_q       <= 1'b1;
            mul_start_q <= 1'b0;
            state       <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          gnt_q     <= '0;
          done_q    <= '0;
          product_q <= '0;
`ifdef MULT_ARBITER_TIMEOUT_EN
          err_q     <= 1'b0;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.product   = product_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign dbg_state     = state;

`ifdef MULT_ARBITER_TIMEOUT_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: self-checking bench for mult_arbiter with a behavioural
// multiplier whose completion latency is set per operation.
// Expected results are packed {err, done[1:0], product[7:0]} and queued in
// service order predicted by the bench's own round-robin model.
module tb_mult_arbiter;
  import mult_arbiter_pkg::*;

  localparam int TO  = 32;
  localparam int EW  = 11;

  logic   clk;
  logic   reset_n;
  state_t dbg_state;

  mult_arbiter_if bus ();

  mult_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- multiplier model ----------------
  logic [7:0] m_cnt;
  logic [7:0] mul_lat;
  logic       mul_en;
  logic       stray_fin;

  // m_cnt counts earlier cycles with mul_start high: 0 in ISSUE, i in the
  // i-th WAIT cycle, so mul_lat is the number of WAIT cycles.
  always @(posedge clk) begin
    if (!reset_n || !bus.mul_start) m_cnt <= 8'd0;
    else                            m_cnt <= m_cnt + 8'd1;
  end
  assign bus.mul_finish = (mul_en && bus.mul_start && (m_cnt == mul_lat)) || stray_fin;
  assign bus.mul_o      = 8'(bus.mul_a) * 8'(bus.mul_b);

  // ---------------- sticky invariant monitors ----------------
  logic gnt_both = 1'b0;
  logic prod_leak = 1'b0;
  always @(negedge clk) begin
    if (bus.gnt == 2'b11) gnt_both <= 1'b1;
    if (bus.done == 2'b00 && bus.product != 8'd0) prod_leak <= 1'b1;
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic tb_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic err, input logic who, input logic [7:0] prod);
    exp_q.push_back({err, onehot(who), prod});
  endtask

  task automatic sb_compare();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check("unexpected_done", {30'd0, bus.done}, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("product", {24'd0, bus.product}, {24'd0, e[7:0]});
      check("done_onehot", {30'd0, bus.done}, {30'd0, e[9:8]});
      check("gnt_at_done", {30'd0, bus.gnt}, {30'd0, e[9:8]});
      check("err", {31'd0, bus.err}, {31'd0, e[10]});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge with the DUT in IDLE (or leaving DONE).
  task automatic issue(input logic [1:0] r, input logic [3:0] x0, input logic [3:0] y0,
                       input logic [3:0] x1, input logic [3:0] y1, input logic [7:0] lat);
    logic first;
    logic [7:0] p0;
    logic [7:0] p1;
    p0 = 8'(x0) * 8'(y0);
    p1 = 8'(x1) * 8'(y1);
    bus.a0 = x0; bus.b0 = y0; bus.a1 = x1; bus.b1 = y1;
    mul_lat = lat;
    bus.req = r;
    if (r == 2'b11) begin
      first = ~tb_last;
      push_exp(1'b0, first, first ? p1 : p0);
      push_exp(1'b0, ~first, first ? p0 : p1);
      tb_last = ~first;
    end else if (r[1]) begin
      push_exp(1'b0, 1'b1, p1);
      tb_last = 1'b1;
    end else begin
      push_exp(1'b0, 1'b0, p0);
      tb_last = 1'b0;
    end
  endtask

  // Waits up to budget negedges for n done pulses; each pulse is scored and
  // the finished requester drops its req.
  task automatic wait_done(input int n, input int budget, output int got, output int last_cyc);
    got = 0;
    last_cyc = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge clk);
      if (bus.done != 2'b00) begin
        sb_compare();
        bus.req = bus.req & ~bus.done;
        got++;
        last_cyc = cyc;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, {30'd0, bus.gnt}, 32'd0);
    check({tag, "_done"}, {30'd0, bus.done}, 32'd0);
    check({tag, "_err"}, {31'd0, bus.err}, 32'd0);
    check({tag, "_product"}, {24'd0, bus.product}, 32'd0);
    check({tag, "_mul_start"}, {31'd0, bus.mul_start}, 32'd0);
    check({tag, "_mul_a"}, {28'd0, bus.mul_a}, 32'd0);
    check({tag, "_mul_b"}, {28'd0, bus.mul_b}, 32'd0);
    check({tag, "_state"}, {30'd0, dbg_state}, {30'd0, IDLE});
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    bus.req = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    tb_last = 1'b1;
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #300000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "time limit");
  end

  // ---------------- test sequence ----------------
  initial begin
    int got;
    int lc;
    int c0;
    int nexp;
    logic [1:0] r;

    reset_n = 1'b0;
    bus.req = 2'b00;
    bus.a0 = 4'd0; bus.b0 = 4'd0; bus.a1 = 4'd0; bus.b1 = 4'd0;
    mul_lat = 8'd2;
    mul_en = 1'b1;
    stray_fin = 1'b0;
    tb_last = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;

    // Single request, 9-cycle multiplier: 12-cycle latency.
    @(negedge clk);
    c0 = cyc;
    issue(2'b01, 4'd14, 4'd11, 4'd0, 4'd0, 8'd9);
    @(negedge clk);
    check("issue_state", {30'd0, dbg_state}, {30'd0, ISSUE});
    check("issue_gnt", {30'd0, bus.gnt}, 32'd1);
    check("issue_mul_start", {31'd0, bus.mul_start}, 32'd1);
    check("issue_mul_a", {28'd0, bus.mul_a}, 32'd14);
    check("issue_mul_b", {28'd0, bus.mul_b}, 32'd11);
    wait_done(1, 40, got, lc);
    check("single_done_count", got, 1);
    check("single_latency", lc - c0 + 1, 12);
    @(negedge clk);
    check("after_done_gnt", {30'd0, bus.gnt}, 32'd0);
    check("after_done_state", {30'd0, dbg_state}, {30'd0, IDLE});

    // Tie: requester 0 then 1 (pointer reset to 1; req0 served once above,
    // so reset again to exercise the post-reset tie).
    pulse_reset();
    issue(2'b11, 4'd3, 4'd5, 4'd15, 4'd15, 8'd3);
    wait_done(2, 60, got, lc);
    check("tie_done_count", got, 2);

    // Operand change during WAIT does not affect the running multiply.
    @(negedge clk);
    issue(2'b01, 4'd14, 4'd11, 4'd0, 4'd0, 8'd9);
    repeat (4) @(negedge clk);
    check("opchg_in_wait", {30'd0, dbg_state}, {30'd0, WAIT});
    bus.a0 = 4'd2;
    bus.b0 = 4'd3;
    @(negedge clk);
    check("opchg_mul_a", {28'd0, bus.mul_a}, 32'd14);
    check("opchg_mul_b", {28'd0, bus.mul_b}, 32'd11);
    wait_done(1, 40, got, lc);
    check("opchg_done_count", got, 1);

    // Request dropped mid-operation still completes.
    @(negedge clk);
    issue(2'b10, 4'd0, 4'd0, 4'd6, 4'd7, 8'd5);
    repeat (3) @(negedge clk);
    bus.req = 2'b00;
    wait_done(1, 30, got, lc);
    check("drop_done_count", got, 1);

    // Stray mul_finish in IDLE is ignored.
    @(negedge clk);
    stray_fin = 1'b1;
    repeat (4) @(negedge clk);
    stray_fin = 1'b0;
    check("stray_state", {30'd0, dbg_state}, {30'd0, IDLE});
    check("stray_done", {30'd0, bus.done}, 32'd0);

    // Reset mid-WAIT aborts with no done; next request still works.
    bus.a0 = 4'd7; bus.b0 = 4'd7; mul_lat = 8'd20; bus.req = 2'b01;
    repeat (5) @(negedge clk);
    check("abort_in_wait", {30'd0, dbg_state}, {30'd0, WAIT});
    pulse_reset();
    check_idle_outputs("abort");
    wait_done(1, 30, got, lc);
    check("abort_no_done", got, 0);
    issue(2'b10, 4'd0, 4'd0, 4'd9, 4'd9, 8'd4);
    wait_done(1, 30, got, lc);
    check("post_abort_done_count", got, 1);

    // Random traffic, reissued straight after each done.
    for (int k = 0; k < 10; k++) begin
      r = 2'($urandom_range(1, 3));
      nexp = (r == 2'b11) ? 2 : 1;
      issue(r, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            8'($urandom_range(1, 6)));
      wait_done(nexp, 80, got, lc);
      check("rand_done_count", got, nexp);
    end

    // Multiplier never finishes.
    @(negedge clk);
    @(negedge clk);
    mul_en = 1'b0;
`ifdef MULT_ARBITER_TIMEOUT_EN
    c0 = cyc;
    bus.a0 = 4'd5; bus.b0 = 4'd5; bus.req = 2'b01;
    push_exp(1'b1, 1'b0, 8'd0);
    tb_last = 1'b0;
    wait_done(1, 80, got, lc);
    check("timeout_done_count", got, 1);
    check("timeout_latency", lc - c0 + 1, 3 + TO);
`else
    bus.a0 = 4'd5; bus.b0 = 4'd5; bus.req = 2'b01;
    repeat (60) @(negedge clk);
    check("nowdog_state", {30'd0, dbg_state}, {30'd0, WAIT});
    check("nowdog_err", {31'd0, bus.err}, 32'd0);
    check("nowdog_done", {30'd0, bus.done}, 32'd0);
    pulse_reset();
`endif
    mul_en = 1'b1;
    repeat (3) @(negedge clk);

    check("gnt_never_both", {31'd0, gnt_both}, 32'd0);
    check("product_zero_without_done", {31'd0, prod_leak}, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
